// File: rtl/game_sequencer.sv
// Game-flow controller: screen selection from PS/2 keys, frame-driven round countdown, saturating score.
// Optional pause screen is built when GAME_SEQ_PAUSE_EN is defined.
module game_sequencer #(
    parameter logic [15:0] START_KEY      = 16'h005A,
    parameter logic [15:0] PAUSE_KEY      = 16'h004D,
    parameter int unsigned ROUND_SECONDS  = 30,
    parameter int unsigned FRAMES_PER_SEC = 60,
    parameter int unsigned MAX_POINTS     = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] keycode,
    input  logic        frame_tick,
    input  logic        hit,
    output logic [1:0]  screen,
    output logic [4:0]  points,
    output logic [5:0]  time_left,
    output logic        round_active
);

    localparam int unsigned FRAME_W    = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_SEC - 1);
    localparam logic [5:0]  ROUND_INIT = 6'(ROUND_SECONDS);
    localparam logic [4:0]  MAX_P      = 5'(MAX_POINTS);
`ifdef GAME_SEQ_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        MENU  = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    state_t             state_q, state_n;
    logic [15:0]        key_q;
    logic [FRAME_W-1:0] frame_q, frame_n;
    logic [4:0]         points_q, points_n;
    logic [5:0]         time_q, time_n;
    logic               active_q;
    logic               key_evt_c, start_evt_c, pause_evt_c, done_c;

    // A key event is a change of code that is not a break code; holding a key repeats nothing.
    assign key_evt_c   = (keycode != key_q) && (keycode[15:8] != 8'hF0);
    assign start_evt_c = key_evt_c && (keycode == START_KEY);
    assign pause_evt_c = PAUSE_EN && key_evt_c && (keycode == PAUSE_KEY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MENU;
            key_q    <= '0;
            frame_q  <= '0;
            points_q <= '0;
            time_q   <= ROUND_INIT;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            key_q    <= keycode;
            frame_q  <= frame_n;
            points_q <= points_n;
            time_q   <= time_n;
            active_q <= (state_n == PLAY);
        end
    end

    // Next state and counter updates; counters only move in PLAY.
    always_comb begin
        state_n  = state_q;
        frame_n  = frame_q;
        points_n = points_q;
        time_n   = time_q;
        done_c   = 1'b0;
        case (state_q)
            MENU: begin
                if (start_evt_c) begin
                    state_n  = PLAY;
                    points_n = '0;
                    time_n   = ROUND_INIT;
                    frame_n  = '0;
                end
            end
            PLAY: begin
                if (hit && (points_q != MAX_P)) begin
                    points_n = points_q + 5'd1;
                    if (points_q == (MAX_P - 5'd1)) begin
                        done_c = 1'b1;
                    end
                end
                if (frame_tick) begin
                    if (frame_q == FRAME_LAST) begin
                        frame_n = '0;
                        if (time_q != 6'd0) begin
                            time_n = time_q - 6'd1;
                        end
                        if (time_q == 6'd1) begin
                            done_c = 1'b1;
                        end
                    end else begin
                        frame_n = frame_q + FRAME_W'(1);
                    end
                end
                // Round end takes priority over a pause request in the same cycle.
                if (done_c) begin
                    state_n = OVER;
                end else if (pause_evt_c) begin
                    state_n = PAUSE;
                end
            end
            OVER: begin
                if (start_evt_c) begin
                    state_n = MENU;
                end
            end
`ifdef GAME_SEQ_PAUSE_EN
            PAUSE: begin
                if (pause_evt_c) begin
                    state_n = PLAY;
                end
            end
`endif
            default: begin
                state_n = MENU;
            end
        endcase
    end

    assign screen       = 2'(state_q);
    assign points       = points_q;
    assign time_left    = time_q;
    assign round_active = active_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: per-cycle scoreboard against a behavioural model plus directed checks.
module tb_game_sequencer;

    localparam logic [15:0] KEY_START = 16'h005A;
    localparam logic [15:0] KEY_PAUSE = 16'h004D;
    localparam logic [15:0] BRK_START = 16'hF05A;
    localparam logic [15:0] BRK_PAUSE = 16'hF04D;
    localparam logic [15:0] KEY_OTHER = 16'h001C;
    localparam int unsigned ROUND = 3;
    localparam int unsigned FPS   = 2;
    localparam int unsigned MAXP  = 4;
`ifdef GAME_SEQ_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] keycode = 16'h0000;
    logic        frame_tick = 1'b0;
    logic        hit = 1'b0;
    logic [1:0]  screen;
    logic [4:0]  points;
    logic [5:0]  time_left;
    logic        round_active;

    game_sequencer #(
        .START_KEY      (KEY_START),
        .PAUSE_KEY      (KEY_PAUSE),
        .ROUND_SECONDS  (ROUND),
        .FRAMES_PER_SEC (FPS),
        .MAX_POINTS     (MAXP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .keycode      (keycode),
        .frame_tick   (frame_tick),
        .hit          (hit),
        .screen       (screen),
        .points       (points),
        .time_left    (time_left),
        .round_active (round_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] screen;
        logic [4:0] points;
        logic [5:0] tleft;
        logic       active;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    string       phase = "init";
    int          m_screen, m_points, m_time, m_frame;
    logic [15:0] m_key;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s/%s got %0d expected %0d at %0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_screen = 0;
        m_points = 0;
        m_time   = ROUND;
        m_frame  = 0;
        m_key    = 16'h0000;
    endtask

    // Behavioural reference of one clock: screen flow, countdown and score.
    task automatic model_step(input logic [15:0] kc, input bit tick, input bit h);
        bit   evt;
        bit   over;
        int   nxt;
        exp_t e;
        evt   = (kc != m_key) && (kc[15:8] != 8'hF0);
        m_key = kc;
        nxt   = m_screen;
        over  = 1'b0;
        case (m_screen)
            0: if (evt && kc == KEY_START) begin
                nxt = 1; m_points = 0; m_time = ROUND; m_frame = 0;
            end
            1: begin
                if (h && m_points < MAXP) begin
                    m_points++;
                    if (m_points == MAXP) over = 1'b1;
                end
                if (tick) begin
                    m_frame++;
                    if (m_frame == FPS) begin
                        m_frame = 0;
                        m_time--;
                        if (m_time == 0) over = 1'b1;
                    end
                end
                if (over) nxt = 2;
                else if (PAUSE_EN && evt && kc == KEY_PAUSE) nxt = 3;
            end
            2: if (evt && kc == KEY_START) nxt = 0;
            default: if (evt && kc == KEY_PAUSE) nxt = 1;
        endcase
        m_screen = nxt;
        e.screen = 2'(m_screen);
        e.points = 5'(m_points);
        e.tleft  = 6'(m_time);
        e.active = (m_screen == 1);
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs, predict, then compare the registered result.
    task automatic step(input logic [15:0] kc, input bit tick, input bit h);
        exp_t e;
        keycode    = kc;
        frame_tick = tick;
        hit        = h;
        model_step(kc, tick, h);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        hit        = 1'b0;
        e = exp_q.pop_front();
        check("screen", int'(screen), int'(e.screen));
        check("points", int'(points), int'(e.points));
        check("time_left", int'(time_left), int'(e.tleft));
        check("round_active", int'(round_active), int'(e.active));
    endtask

    task automatic reset_dut();
        rst        = 1'b1;
        keycode    = 16'h0000;
        frame_tick = 1'b0;
        hit        = 1'b0;
        #2;
        check("rst_screen", int'(screen), 0);
        check("rst_points", int'(points), 0);
        check("rst_time", int'(time_left), ROUND);
        check("rst_active", int'(round_active), 0);
        model_reset();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic start_round();
        step(BRK_START, 1'b0, 1'b0);
        step(KEY_START, 1'b0, 1'b0);
    endtask

    initial begin
        #1;
        phase = "reset";
        reset_dut();

        phase = "start";
        step(KEY_START, 1'b0, 1'b0);
        check("start_screen", int'(screen), 1);
        check("start_active", int'(round_active), 1);
        step(KEY_START, 1'b1, 1'b0);
        step(KEY_START, 1'b0, 1'b1);
        phase = "mid_reset";
        reset_dut();

        phase = "countdown";
        start_round();
        for (int i = 1; i <= 6; i++) begin
            step(KEY_START, 1'b1, 1'b0);
            check("cd_time", int'(time_left), ROUND - i / 2);
        end
        check("cd_over", int'(screen), 2);
        repeat (3) step(KEY_START, 1'b1, 1'b1);
        check("cd_frozen_time", int'(time_left), 0);
        check("cd_frozen_pts", int'(points), 0);

        phase = "key_hold";
        step(BRK_START, 1'b0, 1'b0);
        repeat (100) step(KEY_START, 1'b0, 1'b0);
        check("hold_menu", int'(screen), 0);
        start_round();
        check("restart_screen", int'(screen), 1);
        check("restart_pts", int'(points), 0);
        check("restart_time", int'(time_left), ROUND);

        phase = "score";
        for (int i = 1; i <= 4; i++) begin
            step(KEY_START, 1'b0, 1'b1);
            check("score_pts", int'(points), i);
            step(KEY_START, 1'b0, 1'b0);
        end
        check("score_over", int'(screen), 2);
        step(KEY_START, 1'b0, 1'b1);
        check("score_sat", int'(points), 4);

        phase = "pause";
        start_round();
        start_round();
        step(KEY_START, 1'b1, 1'b0);
        step(KEY_START, 1'b1, 1'b0);
        check("pause_t2", int'(time_left), 2);
        step(KEY_PAUSE, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(KEY_PAUSE, 1'b1, i < 3);
`ifdef GAME_SEQ_PAUSE_EN
        check("paused_screen", int'(screen), 3);
        check("paused_time", int'(time_left), 2);
        check("paused_pts", int'(points), 0);
        step(BRK_PAUSE, 1'b0, 1'b0);
        step(KEY_PAUSE, 1'b0, 1'b0);
        check("resume_screen", int'(screen), 1);
        step(KEY_PAUSE, 1'b1, 1'b0);
        step(KEY_PAUSE, 1'b1, 1'b0);
        check("resume_time", int'(time_left), 1);
`else
        check("nopause_over", int'(screen), 2);
        check("nopause_time", int'(time_left), 0);
        check("nopause_pts", int'(points), 3);
`endif

        phase = "simul_hit_expiry";
        reset_dut();
        start_round();
        repeat (5) step(KEY_START, 1'b1, 1'b0);
        step(KEY_START, 1'b1, 1'b1);
        check("sim_pts", int'(points), 1);
        check("sim_time", int'(time_left), 0);
        check("sim_over", int'(screen), 2);

        phase = "simul_hit_pause";
        reset_dut();
        start_round();
        step(KEY_PAUSE, 1'b0, 1'b1);
        check("hp_pts", int'(points), 1);
`ifdef GAME_SEQ_PAUSE_EN
        check("hp_screen", int'(screen), 3);
`else
        check("hp_screen", int'(screen), 1);
`endif

        phase = "simul_expiry_pause";
        reset_dut();
        start_round();
        repeat (5) step(KEY_START, 1'b1, 1'b0);
        step(KEY_PAUSE, 1'b1, 1'b0);
        check("ep_screen", int'(screen), 2);

        phase = "random";
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            logic [15:0] kc;
            case ($urandom_range(0, 5))
                0: kc = KEY_START;
                1: kc = BRK_START;
                2: kc = KEY_PAUSE;
                3: kc = BRK_PAUSE;
                4: kc = KEY_OTHER;
                default: kc = 16'h0000;
            endcase
            step(kc, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
